// File: rtl/counter_pkg.sv
// Shared definitions for the dual-channel enable counter and its command driver.
package counter_pkg;

    // Enabled cycles per channel-1 increment unless overridden.
    localparam int DIV_DEFAULT = 4;

    // Width of both counter outputs; the driver's shadows match it.
    localparam int OUT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Divide-phase register width: clog2(div), never narrower than one bit.
    function automatic int phase_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/counter_driver_if.sv
// Command handshake between a command source and the counter driver.
interface counter_driver_if #(
    parameter int CNT_W = 16
) ();

    logic             CmdValid;
    logic             CmdReady;
    logic             CmdSel;
    logic [CNT_W-1:0] CmdCount;
    logic             Hold;
    logic             Abort;
    logic             Done;
    logic             Aborted;

    // Command source side.
    modport master (
        output CmdValid, CmdSel, CmdCount, Hold, Abort,
        input  CmdReady, Done, Aborted
    );

    // Driver side.
    modport slave (
        input  CmdValid, CmdSel, CmdCount, Hold, Abort,
        output CmdReady, Done, Aborted
    );

endinterface

// File: rtl/counter_shadow.sv
// Cycle-exact shadow of the counter: divide phase plus both 64-bit outputs.
module counter_shadow
    import counter_pkg::*;
#(
    parameter  int DIV  = DIV_DEFAULT,
    localparam int PH_W = phase_width(DIV)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Slt,
    output logic [PH_W-1:0]  Phase,
    output logic [OUT_W-1:0] Shadow0,
    output logic [OUT_W-1:0] Shadow1,
    output logic             Wrap
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

    logic [PH_W-1:0]  phase_q,   phase_d;
    logic [OUT_W-1:0] shadow0_q, shadow0_d;
    logic [OUT_W-1:0] shadow1_q, shadow1_d;

    // Channel 1 completes an increment on the enabled cycle that leaves the last phase.
    assign Wrap = En && Slt && (phase_q == PH_LAST);

    // Next-state: channel 0 counts every enabled cycle, channel 1 every DIV-th.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        phase_d   = phase_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        if (En) begin
            if (!Slt) begin
                shadow0_d = shadow0_q + 1'b1;
            end else if (Wrap) begin
                phase_d   = '0;
                shadow1_d = shadow1_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // State registers with the shared synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (Reset) begin
            phase_q   <= '0;
            shadow0_q <= '0;
            shadow1_q <= '0;
        end else begin
            phase_q   <= phase_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
        end
    end

    assign Phase   = phase_q;
    assign Shadow0 = shadow0_q;
    assign Shadow1 = shadow1_q;

endmodule

// File: rtl/counter_driver.sv
// Command-driven initiator: advances counter channel Slt by exactly N output counts.
module counter_driver
    import counter_pkg::*;
#(
    parameter  int CNT_W = 16,
    parameter  int DIV   = DIV_DEFAULT,
    localparam int PH_W  = phase_width(DIV)
) (
    input  logic             Clk,
    input  logic             Reset,
    counter_driver_if.slave  cmd,
    output logic             En,
    output logic             Slt,
    output logic [PH_W-1:0]  Phase,
    output logic [OUT_W-1:0] Shadow0,
    output logic [OUT_W-1:0] Shadow1
);

    state_e           state_q;
    logic             slt_q;
    logic             done_q;
    logic             aborted_q;
    logic [CNT_W-1:0] remaining_q;

    logic wrap;
    logic count_step;

    // Enable only while running, and never in a Hold or Abort cycle.
    assign En = (state_q == RUN) && !cmd.Hold && !cmd.Abort;

    // One output increment lands this cycle: every channel-0 enable, or a channel-1 wrap.
    assign count_step = En && (!slt_q || wrap);

    assign cmd.CmdReady = (state_q == IDLE);
    assign cmd.Done     = done_q;
    assign cmd.Aborted  = aborted_q;
    assign Slt          = slt_q;

    counter_shadow #(
        .DIV (DIV)
    ) u_shadow (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .Slt     (slt_q),
        .Phase   (Phase),
        .Shadow0 (Shadow0),
        .Shadow1 (Shadow1),
        .Wrap    (wrap)
    );

    // Command FSM: accept in IDLE, count down in RUN, pulse Done for one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            slt_q       <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd.CmdValid) begin
                        slt_q       <= cmd.CmdSel;
                        remaining_q <= cmd.CmdCount;
                        if (cmd.CmdCount == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cmd.Abort) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (count_step) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_driver.sv
// Self-checking bench: counter model compared every cycle, plus command-level checks.
module tb_counter_driver;
    import counter_pkg::*;

    localparam int CNT_W = 16;
    localparam int DIV   = 4;
    localparam int PH_W  = phase_width(DIV);

    logic             Clk;
    logic             Reset;
    logic             En;
    logic             Slt;
    logic [PH_W-1:0]  Phase;
    logic [OUT_W-1:0] Shadow0;
    logic [OUT_W-1:0] Shadow1;

    counter_driver_if #(.CNT_W(CNT_W)) cmd ();

    counter_driver #(
        .CNT_W (CNT_W),
        .DIV   (DIV)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .cmd     (cmd),
        .En      (En),
        .Slt     (Slt),
        .Phase   (Phase),
        .Shadow0 (Shadow0),
        .Shadow1 (Shadow1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model of the dual-channel enable counter.
    logic [63:0] cnt_o0 = '0;
    logic [63:0] cnt_o1 = '0;
    int          cnt_ph = 0;
    bit          en_s   = 1'b0;
    bit          slt_s  = 1'b0;
    bit          rst_s  = 1'b1;
    bit          chk_on = 1'b0;

    // Compare shadows with the counter each cycle, then capture settled inputs.
    always @(negedge Clk) begin
        if (chk_on) begin
            check("shadow0_vs_output0", Shadow0, cnt_o0);
            check("shadow1_vs_output1", Shadow1, cnt_o1);
            check("phase_vs_counter", 64'(Phase), 64'(cnt_ph));
        end
        #3;
        en_s  = En;
        slt_s = Slt;
        rst_s = Reset;
    end

    // Counter update on the active edge.
    always @(posedge Clk) begin
        if (rst_s) begin
            cnt_o0 = '0;
            cnt_o1 = '0;
            cnt_ph = 0;
        end else if (en_s) begin
            if (!slt_s) begin
                cnt_o0 = cnt_o0 + 1;
            end else begin
                cnt_ph = cnt_ph + 1;
                if (cnt_ph == DIV) begin
                    cnt_ph = 0;
                    cnt_o1 = cnt_o1 + 1;
                end
            end
        end
    end

    // Issue one command starting at a negedge; return observed En count, RUN cycles, Aborted.
    task automatic run_cmd(input bit sel, input int count, input int abort_at,
                           input int hold_at, input int hold_len, input bit rnd_hold,
                           output int en_cnt, output int run_cyc, output bit ab);
        int  holds = 0;
        bit  seen  = 1'b0;
        en_cnt  = 0;
        run_cyc = 0;
        ab      = 1'b0;
        check("ready_before_cmd", cmd.CmdReady, 1'b1);
        cmd.CmdValid = 1'b1;
        cmd.CmdSel   = sel;
        cmd.CmdCount = CNT_W'(count);
        @(posedge Clk);
        @(negedge Clk);
        cmd.CmdValid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd.Done) begin
                ab   = cmd.Aborted;
                seen = 1'b1;
                break;
            end
            cmd.Abort = (en_cnt == abort_at);
            if (rnd_hold) begin
                cmd.Hold = ($urandom_range(0, 3) == 0);
            end else begin
                cmd.Hold = (en_cnt == hold_at) && (holds < hold_len);
                if (cmd.Hold) holds++;
            end
            #1;
            if (En) begin
                en_cnt++;
                check("slt_during_run", Slt, sel);
            end
            run_cyc++;
            @(negedge Clk);
        end
        cmd.Hold  = 1'b0;
        cmd.Abort = 1'b0;
        if (!seen) check("done_timeout", 1'b0, 1'b1);
        @(negedge Clk);
        check("done_one_cycle", cmd.Done, 1'b0);
        check("ready_after_done", cmd.CmdReady, 1'b1);
    endtask

    typedef struct {
        bit          sel;
        int          count;
        int          exp_en;
        logic [63:0] exp_d0;
        logic [63:0] exp_d1;
    } vec_t;

    vec_t vt [6];

    initial begin
        int          en_cnt, run_cyc, p, full, exp_en, abort_at, sel, count;
        bit          ab, exp_ab;
        logic [63:0] s0, s1;

        vt[0] = '{sel: 1'b0, count: 5, exp_en: 5,  exp_d0: 5, exp_d1: 0};
        vt[1] = '{sel: 1'b1, count: 2, exp_en: 8,  exp_d0: 0, exp_d1: 2};
        vt[2] = '{sel: 1'b0, count: 0, exp_en: 0,  exp_d0: 0, exp_d1: 0};
        vt[3] = '{sel: 1'b1, count: 1, exp_en: 4,  exp_d0: 0, exp_d1: 1};
        vt[4] = '{sel: 1'b0, count: 1, exp_en: 1,  exp_d0: 1, exp_d1: 0};
        vt[5] = '{sel: 1'b1, count: 3, exp_en: 12, exp_d0: 0, exp_d1: 3};

        Reset        = 1'b1;
        cmd.CmdValid = 1'b0;
        cmd.CmdSel   = 1'b0;
        cmd.CmdCount = '0;
        cmd.Hold     = 1'b0;
        cmd.Abort    = 1'b0;
        repeat (2) @(negedge Clk);
        Reset  = 1'b0;
        chk_on = 1'b1;
        check("reset_ready", cmd.CmdReady, 1'b1);
        check("reset_done", cmd.Done, 1'b0);
        check("reset_aborted", cmd.Aborted, 1'b0);
        check("reset_slt", Slt, 1'b0);
        check("reset_en", En, 1'b0);
        check("reset_shadow0", Shadow0, 64'd0);
        check("reset_shadow1", Shadow1, 64'd0);
        check("reset_phase", 64'(Phase), 64'd0);
        @(negedge Clk);

        // Table: complete commands from phase 0, no Hold or Abort.
        for (int i = 0; i < 6; i++) begin
            s0 = cnt_o0;
            s1 = cnt_o1;
            run_cmd(vt[i].sel, vt[i].count, -1, -1, 0, 1'b0, en_cnt, run_cyc, ab);
            check("tbl_en_cycles", 64'(en_cnt), 64'(vt[i].exp_en));
            check("tbl_run_cycles", 64'(run_cyc), 64'(vt[i].exp_en));
            check("tbl_aborted", ab, 1'b0);
            check("tbl_shadow0", Shadow0, s0 + vt[i].exp_d0);
            check("tbl_shadow1", Shadow1, s1 + vt[i].exp_d1);
            check("tbl_phase_end", 64'(Phase), 64'd0);
        end

        // Abort after 6 enables of a 3-count channel-1 command, then resume from phase 2.
        s1 = cnt_o1;
        run_cmd(1'b1, 3, 6, -1, 0, 1'b0, en_cnt, run_cyc, ab);
        check("abort_aborted", ab, 1'b1);
        check("abort_en", 64'(en_cnt), 64'd6);
        check("abort_shadow1", Shadow1, s1 + 64'd1);
        check("abort_phase", 64'(Phase), 64'd2);
        run_cmd(1'b1, 1, -1, -1, 0, 1'b0, en_cnt, run_cyc, ab);
        check("resume_en", 64'(en_cnt), 64'd2);
        check("resume_shadow1", Shadow1, s1 + 64'd2);
        check("resume_phase", 64'(Phase), 64'd0);
        check("resume_aborted", ab, 1'b0);

        // Hold for 3 cycles after two enables of a 4-count channel-0 command.
        s0 = cnt_o0;
        run_cmd(1'b0, 4, -1, 2, 3, 1'b0, en_cnt, run_cyc, ab);
        check("hold_en", 64'(en_cnt), 64'd4);
        check("hold_run_cycles", 64'(run_cyc), 64'd7);
        check("hold_shadow0", Shadow0, s0 + 64'd4);

        // Random commands against an arithmetic reference.
        for (int k = 0; k < 40; k++) begin
            sel   = int'($urandom_range(0, 1));
            count = int'($urandom_range(0, 5));
            p     = cnt_ph;
            s0    = cnt_o0;
            s1    = cnt_o1;
            if (count == 0)    full = 0;
            else if (sel == 1) full = (DIV - 1 - p) + 1 + DIV * (count - 1);
            else               full = count;
            abort_at = -1;
            if (full > 0 && $urandom_range(0, 2) == 0) abort_at = int'($urandom_range(0, full - 1));
            exp_ab = (abort_at >= 0);
            exp_en = exp_ab ? abort_at : full;
            run_cmd(sel[0], count, abort_at, -1, 0, 1'b1, en_cnt, run_cyc, ab);
            check("rnd_en", 64'(en_cnt), 64'(exp_en));
            check("rnd_aborted", ab, exp_ab);
            if (sel == 0) begin
                check("rnd_shadow0", Shadow0, s0 + 64'(exp_en));
                check("rnd_shadow1", Shadow1, s1);
                check("rnd_phase", 64'(Phase), 64'(p));
            end else begin
                check("rnd_shadow0", Shadow0, s0);
                check("rnd_shadow1", Shadow1, s1 + 64'((p + exp_en) / DIV));
                check("rnd_phase", 64'(Phase), 64'((p + exp_en) % DIV));
            end
        end

        // Reset mid-run with CmdValid held high during RUN.
        cmd.CmdValid = 1'b1;
        cmd.CmdSel   = 1'b1;
        cmd.CmdCount = CNT_W'(10);
        @(posedge Clk);
        @(negedge Clk);
        cmd.CmdSel   = 1'b0;
        cmd.CmdCount = '0;
        en_cnt = 0;
        for (int i = 0; i < 50 && en_cnt < 5; i++) begin
            #1;
            if (En) en_cnt++;
            check("midrun_ready_low", cmd.CmdReady, 1'b0);
            check("midrun_slt", Slt, 1'b1);
            check("midrun_no_done", cmd.Done, 1'b0);
            @(negedge Clk);
        end
        check("midrun_en_reached", 64'(en_cnt), 64'd5);
        Reset        = 1'b1;
        cmd.CmdValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_ready", cmd.CmdReady, 1'b1);
        check("rst_done", cmd.Done, 1'b0);
        check("rst_phase", 64'(Phase), 64'd0);
        check("rst_shadow0", Shadow0, 64'd0);
        check("rst_shadow1", Shadow1, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_no_done", cmd.Done, 1'b0);
            check("rst_idle", cmd.CmdReady, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
